// File: rtl/banco_pkg.sv
// Shared types and sizes for the register-bank write arbiter.
// Optional sweep-on-reset feature: ARBITRO_CLEAR_ON_RESET_EN.
package banco_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef logic idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its pointer register.
// The pointer names the requester preferred on contention.
module rr_arb2
  import banco_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  idx_t ptr_q;
  idx_t ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (1'b1)
        (valid_i == 2'b11):
          gnt_o = ptr_q ? 2'b10 : 2'b01;
        (valid_i == 2'b01),
        (valid_i == 2'b10):
          gnt_o = valid_i;
        default:
          gnt_o = 2'b00;
      endcase
    end
  end

  // Winner loses priority to the other side.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0]) ptr_d = 1'b1;
    if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/arbitro_escritura_banco.sv
// Shares the bank write port between two requesters.
// Define ARBITRO_CLEAR_ON_RESET_EN to sweep the bank to 0 after reset.
module arbitro_escritura_banco
  import banco_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_dat,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_dat,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] addrW,
  output logic [DATA_W-1:0] datW,
  output logic              RegWrite,
  output logic              grant_id,
  output logic              busy
);

  logic [1:0]        gnt;
  logic              run_en;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              we_q, we_d;
  idx_t              gid_q, gid_d;

`ifdef ARBITRO_CLEAR_ON_RESET_EN
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign run_en = (state_q == RUN);
  assign busy   = (state_q == CLEAR);
`else
  assign run_en = 1'b1;
  assign busy   = 1'b0;
`endif

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({req1_valid, req0_valid}),
    .en_i    (run_en),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    addr_d = addr_q;
    dat_d  = dat_q;
    we_d   = 1'b0;
    gid_d  = gid_q;
`ifdef ARBITRO_CLEAR_ON_RESET_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      addr_d = cnt_q;
      dat_d  = '0;
      we_d   = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = RUN;
    end else
`endif
    if (|gnt) begin
      addr_d = gnt[1] ? req1_addr : req0_addr;
      dat_d  = gnt[1] ? req1_dat  : req0_dat;
      we_d   = 1'b1;
      gid_d  = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      dat_q  <= '0;
      we_q   <= 1'b0;
      gid_q  <= 1'b0;
`ifdef ARBITRO_CLEAR_ON_RESET_EN
      state_q <= CLEAR;
      cnt_q   <= '0;
`endif
    end else begin
      addr_q <= addr_d;
      dat_q  <= dat_d;
      we_q   <= we_d;
      gid_q  <= gid_d;
`ifdef ARBITRO_CLEAR_ON_RESET_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign addrW    = addr_q;
  assign datW     = dat_q;
  assign RegWrite = we_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Scoreboard bench for the bank write arbiter.
// Reference model works from arbitration rules on plain ints and a queue.
module tb_arbitro_escritura_banco;

`ifdef ARBITRO_CLEAR_ON_RESET_EN
  localparam int SWEEP = 16;
`else
  localparam int SWEEP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_addr = '0;
  logic [3:0] req0_dat = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_addr = '0;
  logic [3:0] req1_dat = '0;
  logic       req1_ready;
  logic [3:0] addrW;
  logic [3:0] datW;
  logic       RegWrite;
  logic       grant_id;
  logic       busy;

  arbitro_escritura_banco #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_dat   (req0_dat),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_dat   (req1_dat),
    .req1_ready (req1_ready),
    .addrW      (addrW),
    .datW       (datW),
    .RegWrite   (RegWrite),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct {
    int due;
    int addr;
    int dat;
    int id;
    bit sw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  bit   acc0, acc1;

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d",
               name, cyc, act, exp);
    end
  endtask

  // Reference model: decides the winner from the rules and queues the write.
  initial begin
    int pref, left, idx, w;
    exp_t e;
    pref = 0; left = 0; idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pref = 0;
        left = SWEEP;
        idx  = 0;
      end else if (left > 0) begin
        chk("sweep_ready0", int'(req0_ready), 0);
        chk("sweep_ready1", int'(req1_ready), 0);
        chk("sweep_busy", int'(busy), 1);
        e = '{due: cyc + 1, addr: idx, dat: 0, id: 0, sw: 1'b1};
        q.push_back(e);
        idx++;
        left--;
      end else begin
        w = -1;
        if (req0_valid && req1_valid) w = pref;
        else if (req0_valid)          w = 0;
        else if (req1_valid)          w = 1;
        chk("ready0", int'(req0_ready), int'(w == 0));
        chk("ready1", int'(req1_ready), int'(w == 1));
        chk("busy_run", int'(busy), 0);
        if (w >= 0) begin
          e.due  = cyc + 1;
          e.addr = (w == 0) ? int'(req0_addr) : int'(req1_addr);
          e.dat  = (w == 0) ? int'(req0_dat)  : int'(req1_dat);
          e.id   = w;
          e.sw   = 1'b0;
          q.push_back(e);
          pref = 1 - w;
        end
      end
    end
  end

  // Monitor: compares the bank port against the queued writes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          chk("write_missing", 0, 1);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("regwrite", int'(RegWrite), 1);
          chk("addrW", int'(addrW), e.addr);
          chk("datW", int'(datW), e.dat);
          if (!e.sw) chk("grant_id", int'(grant_id), e.id);
        end else begin
          chk("regwrite_idle", int'(RegWrite), 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    acc0 = req0_valid && req0_ready && !rst;
    acc1 = req1_valid && req1_ready && !rst;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_update();
    if (!req0_valid || acc0) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_addr  = 4'($urandom);
      req0_dat   = 4'($urandom);
    end
    if (!req1_valid || acc1) begin
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_addr  = 4'($urandom);
      req1_dat   = 4'($urandom);
    end
  endtask

  task automatic release_valids();
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    tick();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_addrW", int'(addrW), 0);
    chk("rst_datW", int'(datW), 0);
    chk("rst_regwrite", int'(RegWrite), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_busy", int'(busy), int'(SWEEP > 0));
    @(posedge clk);
    #1;
    repeat (SWEEP + 1) tick();

    req0_valid = 1'b1; req0_addr = 4'd3; req0_dat = 4'd2;
    tick();
    release_valids();
    tick();

    req0_valid = 1'b1; req0_addr = 4'd10; req0_dat = 4'd8;
    req1_valid = 1'b1; req1_addr = 4'd7;  req1_dat = 4'd13;
    repeat (4) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    req1_valid = 1'b1; req1_addr = 4'd0; req1_dat = 4'd9;
    tick();
    release_valids();
    repeat (3) tick();

    req0_valid = 1'b1; req0_addr = 4'd1; req0_dat = 4'd4;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_dat = 4'd5;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (SWEEP + 3) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    if (SWEEP > 0) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (SWEEP + 2) tick();
    end

    for (int i = 0; i < 500; i++) begin
      tick();
      rnd_update();
      rst = ($urandom_range(0, 60) == 0);
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (SWEEP + 4) tick();

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
